// File: rtl/data_select_master_if.sv
// data_select_master_if: request, processor and response signals of the
// select-processor initiator. master = initiator side, slave = environment.
interface data_select_master_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [1:0] req_op;
  logic [7:0] dp_a;
  logic [7:0] dp_b;
  logic [1:0] dp_select;
  logic [8:0] dp_c;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [8:0] rsp_data;
  logic [7:0] rsp_sat;
  logic       rsp_ovf;
  logic [1:0] rsp_op;
  logic [7:0] ovf_cnt;

  modport master (
    input  req_valid, req_a, req_b, req_op,
    input  dp_c, rsp_ready,
    output req_ready, dp_a, dp_b, dp_select,
    output rsp_valid, rsp_data, rsp_sat,
    output rsp_ovf, rsp_op, ovf_cnt
  );

  modport slave (
    output req_valid, req_a, req_b, req_op,
    output dp_c, rsp_ready,
    input  req_ready, dp_a, dp_b, dp_select,
    input  rsp_valid, rsp_data, rsp_sat,
    input  rsp_ovf, rsp_op, ovf_cnt
  );
endinterface

// File: rtl/data_select_master.sv
// data_select_master: one-at-a-time initiator for the registered signed
// select processor; returns raw, saturated and overflow-flagged results.
// Ports: clk, rst (sync, active high), bus (master modport):
//   req_* in/ready out, dp_* to processor, dp_c back, rsp_* out/ready in,
//   ovf_cnt = saturating count of overflowing results.
module data_select_master #(
  parameter int LAT = 1
) (
  input logic                 clk,
  input logic                 rst,
  data_select_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  localparam logic [2:0] LAT_C = 3'(LAT);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [1:0] sel_q, sel_d;
  logic       rv_q, rv_d;
  logic [8:0] data_q, data_d;
  logic [7:0] sat_q, sat_d;
  logic       ovf_q, ovf_d;
  logic [1:0] op_q, op_d;
  logic [7:0] oc_q, oc_d;

  logic       pos_ovf;
  logic       neg_ovf;
  logic [7:0] sat_c;

  // 9-bit value leaves the 8-bit range exactly when bits 8 and 7 differ.
  assign pos_ovf = ~bus.dp_c[8] & bus.dp_c[7];
  assign neg_ovf = bus.dp_c[8] & ~bus.dp_c[7];

  always_comb begin
    sat_c = bus.dp_c[7:0];
    unique case (1'b1)
      pos_ovf: sat_c = 8'h7F;
      neg_ovf: sat_c = 8'h80;
      default: sat_c = bus.dp_c[7:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    rv_d    = rv_q;
    data_d  = data_q;
    sat_d   = sat_q;
    ovf_d   = ovf_q;
    op_d    = op_q;
    oc_d    = oc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          sel_d   = bus.req_op;
          cnt_d   = LAT_C;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          data_d  = bus.dp_c;
          sat_d   = sat_c;
          ovf_d   = pos_ovf | neg_ovf;
          op_d    = sel_q;
          rv_d    = 1'b1;
          state_d = RESP;
          if ((pos_ovf | neg_ovf) && oc_q != 8'hFF)
            oc_d = oc_q + 8'd1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      rv_q    <= 1'b0;
      data_q  <= '0;
      sat_q   <= '0;
      ovf_q   <= 1'b0;
      op_q    <= '0;
      oc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      rv_q    <= rv_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
      op_q    <= op_d;
      oc_q    <= oc_d;
    end
  end

  // Ready is gated by rst so it reads 0 throughout reset.
  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.dp_a      = a_q;
  assign bus.dp_b      = b_q;
  assign bus.dp_select = sel_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_sat   = sat_q;
  assign bus.rsp_ovf   = ovf_q;
  assign bus.rsp_op    = op_q;
  assign bus.ovf_cnt   = oc_q;

endmodule
